// File: rtl/vscale_dmem_responder.sv
// Data-side scratchpad for the vscale dmem port: programmable wait states, late lane-masked
// stores, access-error reporting and same-word store-to-load bypass for back-to-back traffic.
module vscale_dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BASE_W    = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_W   = BASE_W + 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_e;

  function automatic logic access_bad(input logic [31:0] addr, input logic [1:0] size);
    logic out_of_range;
    logic misaligned;
    out_of_range = ({1'b0, addr} < BASE_W) || ({1'b0, addr} >= LIMIT_W);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return out_of_range || misaligned;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = 4'b0011 << lo;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        w[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        w[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return w;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [3:0]    be_q, be_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          bad_q, bad_d;
  logic          wait_q, wait_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          badmem_q, badmem_d;
  logic [31:0]   mem_q [DEPTH];

  logic          accept_s;
  logic          req_bad_s;
  logic [3:0]    req_be_s;
  logic [IW-1:0] req_idx_s;
  logic          wr_en_s;
  logic [31:0]   rd_word_s;
  logic          unused_size_s;

  assign accept_s      = dmem_en && !wait_q;
  assign req_bad_s     = access_bad(dmem_addr, dmem_size[1:0]);
  assign req_be_s      = byte_enables(dmem_size[1:0], dmem_addr[1:0]);
  assign req_idx_s     = IW'((dmem_addr - BASE_ADDR) >> 2);
  assign wr_en_s       = (state_q == S_DATA) && wen_q && !bad_q;
  assign unused_size_s = dmem_size[2];

  assign dmem_wait     = wait_q;
  assign dmem_rdata    = rdata_q;
  assign dmem_badmem_e = badmem_q;

  // Next-state, transaction capture and read-word selection for the data phase being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wen_d     = wen_q;
    be_d      = be_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    rdata_d   = rdata_q;
    badmem_d  = badmem_q;
    rd_word_s = 32'h0000_0000;
    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept_s) begin
          wen_d = dmem_wen;
          be_d  = req_be_s;
          idx_d = req_idx_s;
          bad_d = req_bad_s;
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DATA;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // A store committing this cycle to the word being read must be visible in the read result.
    if (wr_en_s && (idx_q == idx_d)) begin
      rd_word_s = merge_lanes(mem_q[idx_d], dmem_wdata_delayed, be_q);
    end else begin
      rd_word_s = mem_q[idx_d];
    end
    if (state_d == S_DATA) begin
      rdata_d  = bad_d ? 32'h0000_0000 : rd_word_s;
      badmem_d = bad_d;
    end else begin
      rdata_d  = rdata_q;
      badmem_d = badmem_q;
    end
    wait_d = (state_d == S_WAIT);
  end

  // Control state and registered outputs; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      be_q     <= 4'b0000;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      wait_q   <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      badmem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wen_q    <= wen_d;
      be_q     <= be_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      badmem_q <= badmem_d;
    end
  end

  // Store commit at the end of the data-phase cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_q] <= merge_lanes(mem_q[idx_q], dmem_wdata_delayed, be_q);
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Scoreboard bench for vscale_dmem_responder: one instance with no wait states, one with three.
module tb_vscale_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        en    [2];
  logic        wen   [2];
  logic [2:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        dwait [2];
  logic [31:0] rdata [2];
  logic        bad   [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        bad;
  } exp_t;

  exp_t exp_q[$];

  vscale_dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
    .dmem_addr(addr[0]), .dmem_wdata_delayed(wdata[0]), .dmem_wait(dwait[0]),
    .dmem_rdata(rdata[0]), .dmem_badmem_e(bad[0])
  );

  vscale_dmem_responder #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
    .dmem_addr(addr[1]), .dmem_wdata_delayed(wdata[1]), .dmem_wait(dwait[1]),
    .dmem_rdata(rdata[1]), .dmem_badmem_e(bad[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: tracks each accept, counts wait cycles, and checks the data phase against the queue.
  logic busy  [2];
  int   waits [2];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        busy[i]  = 1'b0;
        waits[i] = 0;
      end else begin
        if (busy[i]) begin
          if (dwait[i]) begin
            waits[i]++;
            if (waits[i] > 20) begin
              fail($sformatf("wait_timeout_inst%0d", i));
              busy[i] = 1'b0;
            end
          end else begin
            if (exp_q.size() == 0) begin
              fail($sformatf("unexpected_data_phase_inst%0d", i));
            end else begin
              e = exp_q.pop_front();
              check($sformatf("inst%0d_owner", i), 32'(i), 32'(e.inst));
              check($sformatf("inst%0d_wait_cycles", i), 32'(waits[i]), 32'(wait_of(i)));
              check($sformatf("inst%0d_badmem", i), {31'd0, bad[i]}, {31'd0, e.bad});
              if (e.chk_rdata) begin
                check($sformatf("inst%0d_rdata", i), rdata[i], e.rdata);
              end
            end
            busy[i] = 1'b0;
          end
        end else if (dwait[i]) begin
          fail($sformatf("spurious_wait_inst%0d", i));
        end
        if (en[i] && !dwait[i]) begin
          busy[i]  = 1'b1;
          waits[i] = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request, hold it until accepted, and queue its expected data-phase response.
  task automatic req(input int i, input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic chk,
                     input logic eb, output int held);
    exp_t e;
    logic acc;
    e.inst = i; e.rdata = er; e.chk_rdata = chk; e.bad = eb;
    exp_q.push_back(e);
    en[i] = 1'b1; wen[i] = w; size[i] = sz; addr[i] = a;
    held = 0;
    acc  = 1'b0;
    while (!acc && held <= 40) begin
      @(negedge clk);
      acc = !dwait[i];
      @(posedge clk);
      #1;
      if (!acc) held++;
    end
    if (!acc) fail($sformatf("accept_timeout_inst%0d_addr%08h", i, a));
    en[i] = 1'b0;
    if (w) wdata[i] = d;
  endtask

  task automatic store(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz, input logic eb);
    int h;
    req(i, 1'b1, sz, a, d, 32'h0000_0000, eb, eb, h);
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] er, input logic eb);
    int h;
    req(i, 1'b0, sz, a, 32'h0000_0000, eb ? 32'h0000_0000 : er, 1'b1, eb, h);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int h;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b0; wen[i] = 1'b0; size[i] = 3'd2;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    idle(2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_wait_inst%0d", i), {31'd0, dwait[i]}, 32'd0);
      check($sformatf("reset_rdata_inst%0d", i), rdata[i], 32'h0);
      check($sformatf("reset_badmem_inst%0d", i), {31'd0, bad[i]}, 32'd0);
      rst_n[i] = 1'b1;
    end
    idle(2);

    // Zero-wait instance: word traffic, byte merge, boundary word, errors, bypass.
    store(0, 32'h0000_2000, 32'hDEAD_BEEF, 3'd2, 1'b0);
    load (0, 32'h0000_2000, 3'd2, 32'hDEAD_BEEF, 1'b0);
    store(0, 32'h0000_2004, 32'h1122_3344, 3'd2, 1'b0);
    store(0, 32'h0000_2005, 32'hABAB_ABAB, 3'd0, 1'b0);
    load (0, 32'h0000_2004, 3'd2, 32'h1122_AB44, 1'b0);
    store(0, 32'h0000_2FFC, 32'h0BAD_F00D, 3'd2, 1'b0);
    load (0, 32'h0000_2FFC, 3'd2, 32'h0BAD_F00D, 1'b0);
    load (0, 32'h0000_1FFC, 3'd2, 32'h0, 1'b1);
    store(0, 32'h0000_3000, 32'hFFFF_FFFF, 3'd2, 1'b1);
    load (0, 32'h0000_2001, 3'd1, 32'h0, 1'b1);
    store(0, 32'h0000_2002, 32'hFFFF_FFFF, 3'd2, 1'b1);
    load (0, 32'h0000_2000, 3'd3, 32'h0, 1'b1);
    load (0, 32'h0000_2000, 3'd2, 32'hDEAD_BEEF, 1'b0);
    load (0, 32'h0000_2FFC, 3'd2, 32'h0BAD_F00D, 1'b0);
    store(0, 32'h0000_2008, 32'h0000_0000, 3'd2, 1'b0);
    store(0, 32'h0000_200A, 32'h5566_5566, 3'd1, 1'b0);
    load (0, 32'h0000_2008, 3'd2, 32'h5566_0000, 1'b0);
    idle(4);

    // Three-wait instance: latency and a request held through the wait.
    store(1, 32'h0000_2000, 32'h0102_0304, 3'd2, 1'b0);
    req(1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'h0102_0304, 1'b1, 1'b0, h);
    check("held_request_cycles", 32'(h), 32'd3);
    load (1, 32'h0000_2000, 3'd2, 32'h0102_0304, 1'b0);

    // Reset in the middle of a store's wait phase.
    store(1, 32'h0000_2010, 32'hCAFE_F00D, 3'd2, 1'b0);
    load (1, 32'h0000_2010, 3'd2, 32'hCAFE_F00D, 1'b0);
    idle(6);
    req(1, 1'b1, 3'd2, 32'h0000_2010, 32'h1234_5678, 32'h0, 1'b0, 1'b0, h);
    @(posedge clk);
    #2;
    check("wait_before_reset", {31'd0, dwait[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check("wait_async_drop", {31'd0, dwait[1]}, 32'd0);
    check("rdata_async_clear", rdata[1], 32'h0);
    check("badmem_async_clear", {31'd0, bad[1]}, 32'd0);
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    idle(1);
    load(1, 32'h0000_2010, 3'd2, 32'hCAFE_F00D, 1'b0);

    idle(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
